// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: front end of the K&S datapath.
// Holds the program counter and instruction register. The IR is decoded into an opcode and
// register/memory fields, and those outputs are registered, so fields appear one clock after
// the IR is loaded.
//
// Ports:
//   clk                 system clock, all state changes on the rising edge
//   rst                 synchronous reset, active-high
//   pc_enable           advance PC by one (wraps modulo 2**ADDR_W)
//   ir_enable           capture instr_data into IR
//   branch              load PC from the registered mem_addr; takes priority over pc_enable
//   halt                freeze PC, IR and decode registers; only rst clears them
//   instr_data          word read from program memory at pc_addr
//   pc_addr             current PC
//   decoded_instruction registered decoded opcode
//   a_addr/b_addr       ALU source registers
//   c_addr              destination register
//   mem_addr            LOAD/STORE/branch target address
//   illegal_op          sticky flag, set when an undefined opcode is decoded

package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

endpackage

module fetch_decode_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    branch,
    input  logic                    halt,
    input  logic [INSTR_W-1:0]      instr_data,
    output logic [ADDR_W-1:0]       pc_addr,
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    illegal_op
);

    logic [ADDR_W-1:0]       pc_q;
    logic [INSTR_W-1:0]      ir_q;
    decoded_instruction_type op_q;
    logic [1:0]              a_q, b_q, c_q;
    logic [ADDR_W-1:0]       mem_q;
    logic                    illegal_q;

    decoded_instruction_type op_d;
    logic [1:0]              a_d, b_d, c_d;
    logic [ADDR_W-1:0]       mem_d;
    logic                    illegal_d;
    logic [ADDR_W-1:0]       pc_d;

    // IR bit 7 carries no field for any opcode.
    logic unused_ir_bit;
    assign unused_ir_bit = ir_q[7];

    // Combinational decode of the current IR; the result is registered below.
    always_comb begin
        op_d      = I_NOP;
        a_d       = 2'd0;
        b_d       = 2'd0;
        c_d       = 2'd0;
        mem_d     = '0;
        illegal_d = 1'b0;
        case (ir_q[15:8])
            8'h00: op_d = I_NOP;
            8'h01: begin
                op_d  = I_LOAD;
                c_d   = ir_q[6:5];
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h02: begin
                op_d  = I_STORE;
                a_d   = ir_q[6:5];
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h03: begin
                op_d = I_MOVE;
                c_d  = ir_q[5:4];
                a_d  = ir_q[3:2];
            end
            8'h04, 8'h05, 8'h06, 8'h07: begin
                unique case (ir_q[9:8])
                    2'd0:    op_d = I_ADD;
                    2'd1:    op_d = I_SUB;
                    2'd2:    op_d = I_AND;
                    default: op_d = I_OR;
                endcase
                c_d = ir_q[5:4];
                a_d = ir_q[3:2];
                b_d = ir_q[1:0];
            end
            8'h08: begin
                op_d  = I_BRANCH;
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h09: begin
                op_d  = I_BZERO;
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h0A: begin
                op_d  = I_BNZERO;
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h0B: begin
                op_d  = I_BNEG;
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'h0C: begin
                op_d  = I_BNNEG;
                mem_d = ir_q[ADDR_W-1:0];
            end
            8'hFF: op_d = I_HALT;
            default: begin
                op_d      = I_NOP;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Branch target comes from the registered mem_addr, i.e. the instruction already decoded.
    always_comb begin
        pc_d = pc_q;
        if (branch) begin
            pc_d = mem_q;
        end else if (pc_enable) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            op_q      <= I_NOP;
            a_q       <= 2'd0;
            b_q       <= 2'd0;
            c_q       <= 2'd0;
            mem_q     <= '0;
            illegal_q <= 1'b0;
        end else if (!halt) begin
            pc_q <= pc_d;
            if (ir_enable) begin
                ir_q <= instr_data;
            end
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            mem_q     <= mem_d;
            illegal_q <= illegal_q | illegal_d;
        end
    end

    assign pc_addr             = pc_q;
    assign decoded_instruction = op_q;
    assign a_addr              = a_q;
    assign b_addr              = b_q;
    assign c_addr              = c_q;
    assign mem_addr            = mem_q;
    assign illegal_op          = illegal_q;

endmodule
